// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared memop encodings, FSM states and access classification helpers
package lsu_pkg;

    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LH  = 3'b001;
    localparam logic [2:0] MEMOP_LW  = 3'b010;
    localparam logic [2:0] MEMOP_LBU = 3'b100;
    localparam logic [2:0] MEMOP_LHU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LD_ISSUE0,
        LD_ISSUE1,
        LD_CAPTURE,
        ST_WRITE,
        RESP
    } lsu_state_e;

    function automatic logic [2:0] access_size(input logic [2:0] memop);
        case (memop[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] memop, input logic we);
        if (we)
            return (memop == MEMOP_LB) || (memop == MEMOP_LH) || (memop == MEMOP_LW);
        return (memop == MEMOP_LB) || (memop == MEMOP_LH) || (memop == MEMOP_LW) ||
               (memop == MEMOP_LBU) || (memop == MEMOP_LHU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] memop, input logic [1:0] off);
        return ((memop[1:0] == 2'b01) && off[0]) || ((memop[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    // True when the access needs bytes from the following word as well
    function automatic logic is_spanning(input logic [2:0] memop, input logic [1:0] off);
        return ({2'b00, off} + {1'b0, access_size(memop)}) > 4'd4;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts and extends load data from a two-word window
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] dword_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  memop_i,
    output logic [31:0] rdata_o
);

    logic [31:0] win;

    assign win = 32'(dword_i >> {offset_i, 3'b000});

    always_comb begin
        rdata_o = 32'h0;
        case (memop_i)
            MEMOP_LB:  rdata_o = {{24{win[7]}}, win[7:0]};
            MEMOP_LH:  rdata_o = {{16{win[15]}}, win[15:0]};
            MEMOP_LW:  rdata_o = win;
            MEMOP_LBU: rdata_o = {24'h0, win[7:0]};
            MEMOP_LHU: rdata_o = {16'h0, win[15:0]};
            default:   rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// rtl/lsu_dmem_master.sv - load/store initiator driving the data-memory port
module lsu_dmem_master
    import lsu_pkg::*;
#(
    parameter int ALLOW_MISALIGNED = 1,
    parameter int ADDR_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_memop,
    input  logic                  req_we,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [2:0]            mem_memop,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [31:0]           wdata_q, wdata_d, word0_q, word0_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d, resp_rdata_q, resp_rdata_d;
    logic [2:0]            memop_q, memop_d, mem_memop_q, mem_memop_d;
    logic [2:0]            cnt_q, cnt_d, nwr_q, nwr_d;
    logic                  mem_we_q, mem_we_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic                  req_mis, req_legal, ld_span;
    logic [63:0]           align_dword;
    logic [31:0]           align_result;

    assign req_mis     = is_misaligned(req_memop, req_addr[1:0]);
    assign req_legal   = is_legal(req_memop, req_we);
    assign ld_span     = is_spanning(memop_q, addr_q[1:0]);
    assign align_dword = ld_span ? {mem_rdata, word0_q} : {32'h0, mem_rdata};

    lsu_load_align u_align (
        .dword_i  (align_dword),
        .offset_i (addr_q[1:0]),
        .memop_i  (memop_q),
        .rdata_o  (align_result)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        word0_d      = word0_q;
        memop_d      = memop_q;
        cnt_d        = cnt_q;
        nwr_d        = nwr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_memop_d  = mem_memop_q;
        mem_we_d     = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    memop_d = req_memop;
                    cnt_d   = 3'd1;
                    if (!req_legal || (req_mis && (ALLOW_MISALIGNED == 0))) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d     = LD_ISSUE0;
                        mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_memop_d = MEMOP_LW;
                    end else begin
                        // Misaligned stores become a run of sb writes, byte 0 first
                        state_d     = ST_WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = req_addr;
                        nwr_d       = req_mis ? access_size(req_memop) : 3'd1;
                        mem_memop_d = req_mis ? MEMOP_LB : req_memop;
                        mem_wdata_d = req_mis ? {24'h0, req_wdata[7:0]} : req_wdata;
                    end
                end
            end
            LD_ISSUE0: begin
                if (ld_span) begin
                    state_d    = LD_ISSUE1;
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(4);
                end else begin
                    state_d = LD_CAPTURE;
                end
            end
            LD_ISSUE1: begin
                word0_d = mem_rdata;
                state_d = LD_CAPTURE;
            end
            LD_CAPTURE: begin
                resp_rdata_d = align_result;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            ST_WRITE: begin
                if (cnt_q < nwr_q) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q + ADDR_WIDTH'(cnt_q);
                    mem_memop_d = MEMOP_LB;
                    mem_wdata_d = {24'h0, 8'(wdata_q >> {cnt_q[1:0], 3'b000})};
                    cnt_d       = cnt_q + 3'd1;
                end else begin
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            word0_q      <= 32'h0;
            memop_q      <= MEMOP_LW;
            cnt_q        <= 3'd0;
            nwr_q        <= 3'd0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_memop_q  <= MEMOP_LW;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word0_q      <= word0_d;
            memop_q      <= memop_d;
            cnt_q        <= cnt_d;
            nwr_q        <= nwr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_memop_q  <= mem_memop_d;
            mem_we_q     <= mem_we_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_memop  = mem_memop_q;
    assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb/tb_lsu_dmem_master.sv - self-checking bench for lsu_dmem_master
module tb_lsu_dmem_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we, resp_valid, resp_err, mem_we;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  req_memop, mem_memop;

    logic        s_req_valid, s_req_ready, s_req_we, s_resp_valid, s_resp_err, s_mem_we;
    logic [31:0] s_req_addr, s_req_wdata, s_resp_rdata, s_mem_addr, s_mem_wdata;
    logic [2:0]  s_req_memop, s_mem_memop;
    logic        s_we_seen = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  dmem [logic [31:0]];
    logic [7:0]  refm [logic [31:0]];
    logic [31:0] addr_at [0:15];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [2:0]  wr_op [$];
    int          wr_cyc [$];

    lsu_dmem_master #(.ALLOW_MISALIGNED(1), .ADDR_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_memop(req_memop), .req_we(req_we),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memop(mem_memop), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    lsu_dmem_master #(.ALLOW_MISALIGNED(0), .ADDR_WIDTH(32)) u_strict (
        .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_addr(s_req_addr), .req_wdata(s_req_wdata), .req_memop(s_req_memop), .req_we(s_req_we),
        .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata), .resp_err(s_resp_err),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_memop(s_mem_memop), .mem_we(s_mem_we),
        .mem_rdata(32'h0)
    );

    function automatic logic [7:0] dm_rd(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rf_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : 8'h00;
    endfunction

    function automatic int size_of(input logic [2:0] op);
        return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Reference load: gather bytes little-endian from the model memory, then extend
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
        int sz;
        logic [31:0] v;
        sz = size_of(op);
        v = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rf_rd(a + 32'(i));
        if (!op[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!op[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    always @(posedge clk) begin
        if ($isunknown(mem_addr)) begin
            mem_rdata <= 32'h0;
        end else begin
            mem_rdata <= {dm_rd({mem_addr[31:2], 2'b11}), dm_rd({mem_addr[31:2], 2'b10}),
                          dm_rd({mem_addr[31:2], 2'b01}), dm_rd({mem_addr[31:2], 2'b00})};
            if (mem_we === 1'b1)
                for (int i = 0; i < size_of(mem_memop); i++) dmem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
        end
    end

    always @(posedge clk) if (s_mem_we === 1'b1) s_we_seen <= 1'b1;

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            dmem[a + 32'(i)] = w[8*i +: 8];
            refm[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    task automatic run_req(input logic [31:0] a, input logic [2:0] op, input logic we, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat,
                           output logic rdy_pre, output logic vld_after);
        rdy_pre = req_ready;
        req_valid = 1'b1; req_addr = a; req_memop = op; req_we = we; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_memop = 3'($urandom); req_we = 1'($urandom);
        wr_addr.delete(); wr_data.delete(); wr_op.delete(); wr_cyc.delete();
        lat = 0; rd = 32'h0; er = 1'b0; vld_after = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            addr_at[k] = mem_addr;
            if (mem_we === 1'b1) begin
                wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata);
                wr_op.push_back(mem_memop); wr_cyc.push_back(k);
            end
            if (resp_valid === 1'b1) begin
                rd = resp_rdata; er = resp_err; lat = k;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        vld_after = resp_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({req_ready, resp_valid, resp_err, mem_we, mem_memop} !== 7'b1000_010) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b expected %b", {req_ready, resp_valid, resp_err, mem_we, mem_memop}, 7'b1000_010);
        end
        tests_run++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            tests_failed++;
            $display("FAIL reset_data got %h expected 0", {resp_rdata, mem_addr, mem_wdata});
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({req_ready, s_req_ready, mem_we} !== 3'b110) begin
            tests_failed++;
            $display("FAIL reset_release got %b expected 110", {req_ready, s_req_ready, mem_we});
        end
    endtask

    task automatic test_byte_loads;
        logic [31:0] rd; logic er, rdy, va; int lat;
        set_word(32'h100, 32'h8899AABB);
        run_req(32'h103, 3'b000, 1'b0, 32'h0, rd, er, lat, rdy, va);
        tests_run++;
        if ({rdy, er, va} !== 3'b100 || lat != 3 || rd !== 32'hFFFFFF88 || addr_at[1] !== 32'h100) begin
            tests_failed++;
            $display("FAIL lb_103 got rd=%h lat=%0d addr=%h rdy/err/after=%b expected rd=ffffff88 lat=3 addr=100 100",
                     rd, lat, addr_at[1], {rdy, er, va});
        end
        run_req(32'h103, 3'b100, 1'b0, 32'h0, rd, er, lat, rdy, va);
        tests_run++;
        if (er !== 1'b0 || lat != 3 || rd !== 32'h00000088 || addr_at[1] !== 32'h100) begin
            tests_failed++;
            $display("FAIL lbu_103 got rd=%h lat=%0d addr=%h expected rd=00000088 lat=3 addr=100", rd, lat, addr_at[1]);
        end
    endtask

    task automatic test_spanning_load;
        logic [31:0] rd; logic er, rdy, va; int lat;
        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776655);
        run_req(32'h102, 3'b010, 1'b0, 32'h0, rd, er, lat, rdy, va);
        tests_run++;
        if (addr_at[1] !== 32'h100 || addr_at[2] !== 32'h104) begin
            tests_failed++;
            $display("FAIL lw_102_addr got %h,%h expected 00000100,00000104", addr_at[1], addr_at[2]);
        end
        tests_run++;
        if (er !== 1'b0 || lat != 4 || rd !== 32'h66554433) begin
            tests_failed++;
            $display("FAIL lw_102_data got rd=%h lat=%0d expected rd=66554433 lat=4", rd, lat);
        end
        run_req(32'h103, 3'b101, 1'b0, 32'h0, rd, er, lat, rdy, va);
        tests_run++;
        if (lat != 4 || rd !== 32'h00005544) begin
            tests_failed++;
            $display("FAIL lhu_103 got rd=%h lat=%0d expected rd=00005544 lat=4", rd, lat);
        end
    endtask

    task automatic test_misaligned_store;
        logic [31:0] rd, exp_b; logic er, rdy, va; int lat;
        set_word(32'h200, 32'h11223344);
        set_word(32'h204, 32'h55667788);
        run_req(32'h201, 3'b010, 1'b1, 32'hDEADBEEF, rd, er, lat, rdy, va);
        tests_run++;
        if (wr_addr.size() != 4 || lat != 5 || er !== 1'b0 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL sw_201_shape got writes=%0d lat=%0d err=%b rd=%h expected 4 5 0 0", wr_addr.size(), lat, er, rd);
        end
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            exp_b = 32'hDEADBEEF >> (8 * i);
            tests_run++;
            if (wr_addr[i] !== 32'h201 + 32'(i) || wr_op[i] !== 3'b000 || wr_data[i][7:0] !== exp_b[7:0] || wr_cyc[i] != i + 1) begin
                tests_failed++;
                $display("FAIL sw_201_byte%0d got addr=%h op=%b byte=%h cyc=%0d expected addr=%h op=000 byte=%h cyc=%0d",
                         i, wr_addr[i], wr_op[i], wr_data[i][7:0], wr_cyc[i], 32'h201 + 32'(i), exp_b[7:0], i + 1);
            end
            refm[32'h201 + 32'(i)] = exp_b[7:0];
        end
        run_req(32'h200, 3'b010, 1'b0, 32'h0, rd, er, lat, rdy, va);
        tests_run++;
        if (rd !== 32'hADBEEF44 || lat != 3) begin
            tests_failed++;
            $display("FAIL lw_200_after got rd=%h lat=%0d expected rd=adbeef44 lat=3", rd, lat);
        end
        run_req(32'h204, 3'b010, 1'b0, 32'h0, rd, er, lat, rdy, va);
        tests_run++;
        if (rd !== 32'h556677DE) begin
            tests_failed++;
            $display("FAIL lw_204_after got rd=%h expected 556677de", rd);
        end
    endtask

    task automatic test_reject;
        logic [31:0] rd; logic er, rdy, va; int lat;
        logic [31:0] s_addr [0:2];
        logic [2:0]  s_op [0:2];
        logic        s_we [0:2];
        s_addr = '{32'h103, 32'h100, 32'h201};
        s_op   = '{3'b001, 3'b011, 3'b010};
        s_we   = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            s_req_valid = 1'b1; s_req_addr = s_addr[i]; s_req_memop = s_op[i];
            s_req_we = s_we[i]; s_req_wdata = 32'hFFFF_FFFF;
            @(negedge clk);
            s_req_valid = 1'b0;
            tests_run++;
            if ({s_resp_valid, s_resp_err, s_mem_we} !== 3'b110 || s_resp_rdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL strict_reject%0d got valid/err/we=%b rd=%h expected 110 rd=0",
                         i, {s_resp_valid, s_resp_err, s_mem_we}, s_resp_rdata);
            end
            @(negedge clk);
            tests_run++;
            if ({s_resp_valid, s_req_ready} !== 2'b01) begin
                tests_failed++;
                $display("FAIL strict_after%0d got valid/ready=%b expected 01", i, {s_resp_valid, s_req_ready});
            end
        end
        tests_run++;
        if (s_we_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL strict_no_write got we_seen=%b expected 0", s_we_seen);
        end
        run_req(32'h100, 3'b011, 1'b0, 32'h0, rd, er, lat, rdy, va);
        tests_run++;
        if (er !== 1'b1 || lat != 1 || rd !== 32'h0 || wr_addr.size() != 0) begin
            tests_failed++;
            $display("FAIL illegal_load got err=%b lat=%0d rd=%h writes=%0d expected 1 1 0 0", er, lat, rd, wr_addr.size());
        end
        run_req(32'h100, 3'b100, 1'b1, 32'h12345678, rd, er, lat, rdy, va);
        tests_run++;
        if (er !== 1'b1 || lat != 1 || wr_addr.size() != 0) begin
            tests_failed++;
            $display("FAIL illegal_store got err=%b lat=%0d writes=%0d expected 1 1 0", er, lat, wr_addr.size());
        end
    endtask

    task automatic test_wrap;
        logic [31:0] rd; logic er, rdy, va; int lat;
        set_word(32'hFFFF_FFFC, 32'hA1A2A3A4);
        set_word(32'h0000_0000, 32'hB1B2B3B4);
        run_req(32'hFFFF_FFFE, 3'b010, 1'b0, 32'h0, rd, er, lat, rdy, va);
        tests_run++;
        if (addr_at[1] !== 32'hFFFF_FFFC || addr_at[2] !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_addr got %h,%h expected fffffffc,00000000", addr_at[1], addr_at[2]);
        end
        tests_run++;
        if (rd !== 32'hB3B4A1A2 || lat != 4) begin
            tests_failed++;
            $display("FAIL wrap_data got rd=%h lat=%0d expected rd=b3b4a1a2 lat=4", rd, lat);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er, rdy, va; int lat;
        logic seen_resp;
        set_word(32'h300, 32'h11111111);
        set_word(32'h304, 32'h22222222);
        req_valid = 1'b1; req_addr = 32'h301; req_memop = 3'b010; req_we = 1'b1; req_wdata = 32'hA1B2C3D4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h302) begin
            tests_failed++;
            $display("FAIL midrst_second_sb got we=%b addr=%h expected 1 00000302", mem_we, mem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({mem_we, resp_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL midrst_abort got we/valid=%b expected 00", {mem_we, resp_valid});
        end
        rst = 1'b0;
        seen_resp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid === 1'b1 || mem_we === 1'b1) seen_resp = 1'b1;
        end
        tests_run++;
        if (req_ready !== 1'b1 || seen_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_idle got ready=%b activity=%b expected 1 0", req_ready, seen_resp);
        end
        refm[32'h301] = 8'hD4;
        refm[32'h302] = 8'hC3;
        run_req(32'h308, 3'b010, 1'b1, 32'hCAFEF00D, rd, er, lat, rdy, va);
        tests_run++;
        if (lat != 2 || er !== 1'b0 || wr_addr.size() != 1) begin
            tests_failed++;
            $display("FAIL midrst_sw got lat=%0d err=%b writes=%0d expected 2 0 1", lat, er, wr_addr.size());
        end
        set_word(32'h308, 32'hCAFEF00D);
        run_req(32'h300, 3'b010, 1'b0, 32'h0, rd, er, lat, rdy, va);
        tests_run++;
        if (rd !== ref_load(32'h300, 3'b010) || rd !== 32'h11C3D411) begin
            tests_failed++;
            $display("FAIL midrst_partial got %h expected %h", rd, ref_load(32'h300, 3'b010));
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, wd, exp_rd, exp_a, mask; logic er, rdy, va, we, illegal, mis;
        logic [2:0] op, exp_op; logic [7:0] exp_byte;
        logic [2:0] ld_ops [0:4];
        int lat, exp_lat, exp_nwr, sz, bad;
        ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 32; i++) set_word(32'h400 + 32'(4 * i), $urandom);
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            illegal = ($urandom_range(0, 9) == 0);
            if (illegal) op = we ? 3'($urandom_range(3, 7)) : ((($urandom_range(0, 2)) == 0) ? 3'b011 : 3'($urandom_range(6, 7)));
            else op = we ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
            a = 32'h400 + 32'($urandom_range(0, 27));
            wd = $urandom;
            sz = size_of(op);
            mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
            exp_rd = 32'h0; exp_nwr = 0;
            if (illegal) exp_lat = 1;
            else if (!we) begin
                exp_lat = (int'(a[1:0]) + sz > 4) ? 4 : 3;
                exp_rd = ref_load(a, op);
            end else begin
                exp_nwr = mis ? sz : 1;
                exp_lat = exp_nwr + 1;
            end
            run_req(a, op, we, wd, rd, er, lat, rdy, va);
            tests_run++;
            if (rdy !== 1'b1 || va !== 1'b0 || er !== illegal || lat != exp_lat || rd !== exp_rd || wr_addr.size() != exp_nwr) begin
                tests_failed++;
                $display("FAIL rand%0d a=%h op=%b we=%b got err=%b lat=%0d rd=%h nwr=%0d rdy=%b after=%b expected err=%b lat=%0d rd=%h nwr=%0d rdy=1 after=0",
                         n, a, op, we, er, lat, rd, wr_addr.size(), rdy, va, illegal, exp_lat, exp_rd, exp_nwr);
            end
            for (int i = 0; i < exp_nwr && i < wr_addr.size(); i++) begin
                exp_a  = mis ? a + 32'(i) : a;
                exp_op = mis ? 3'b000 : op;
                mask   = mis ? 32'hFF : ((sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF);
                exp_byte = 8'(wd >> (8 * i));
                tests_run++;
                if (wr_addr[i] !== exp_a || wr_op[i] !== exp_op || wr_cyc[i] != i + 1 ||
                    (wr_data[i] & mask) !== ((mis ? {24'h0, exp_byte} : wd) & mask)) begin
                    tests_failed++;
                    $display("FAIL rand%0d_wr%0d got addr=%h op=%b data=%h cyc=%0d expected addr=%h op=%b data=%h cyc=%0d",
                             n, i, wr_addr[i], wr_op[i], wr_data[i] & mask, wr_cyc[i], exp_a, exp_op,
                             (mis ? {24'h0, exp_byte} : wd) & mask, i + 1);
                end
            end
            if (we && !illegal)
                for (int b = 0; b < sz; b++) refm[a + 32'(b)] = 8'(wd >> (8 * b));
        end
        bad = 0;
        for (int i = 0; i < 136; i++)
            if (dm_rd(32'h400 + 32'(i)) !== rf_rd(32'h400 + 32'(i))) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL rand_mem_image got %0d differing bytes expected 0", bad);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_memop = 3'b010; req_we = 1'b0;
        s_req_valid = 1'b0; s_req_addr = 32'h0; s_req_wdata = 32'h0; s_req_memop = 3'b010; s_req_we = 1'b0;
        test_reset();
        test_byte_loads();
        test_spanning_load();
        test_misaligned_store();
        test_reject();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
Load/store initiator between the CPU memory stage and the data-memory block. Accepts one load/store request at a time and drives the data-memory port. Data memory uses word read 3'b010 for every load and native sb/sh/sw for aligned stores. Splits misaligned accesses into multiple aligned memory cycles and does load byte/half extraction and sign/zero extension itself.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split misaligned accesses; 0 = reject them with resp_err
ADDR_WIDTH, 32, request/memory byte-address width

Ports:
clk  in  1  single clock; data memory rdclk and wrclk are both tied to clk
rst  in  1  reset: synchronous, active-high, sampled on rising clk
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; accept = req_valid && req_ready
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, right-aligned
req_memop  in  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
req_we  in  1  1 = store
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  qualifies resp_valid; illegal memop or rejected misaligned access
mem_addr  out  ADDR_WIDTH  byte address to data memory
mem_wdata  out  32  store data, right-aligned (memory replicates lanes)
mem_memop  out  3  memop to data memory
mem_we  out  1  write strobe, one cycle per write
mem_rdata  in  32  full word; valid the cycle after mem_addr is presented

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_addr=0; mem_memop=3'b010; mem_wdata=0.
- All outputs are registered or decoded only from the state register. No combinational path from req_* to mem_*.
- States: IDLE, LD_ISSUE0, LD_ISSUE1, LD_CAPTURE, ST_WRITE, RESP.
- Legal memops: loads 000,001,010,100,101; stores 000,001,010.
- Misaligned means: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0.
- Illegal memop, or misaligned with ALLOW_MISALIGNED=0: go to RESP. resp_valid=1 and resp_err=1 at T+1. No memory cycle.
- Loads, accept at cycle T:
  - T+1: LD_ISSUE0 drives mem_addr={addr[31:2],2'b00}, memop 010, we=0.
  - Spanning load (byte offset + size > 4): T+2 is LD_ISSUE1. It drives word0+4 (mod 2^ADDR_WIDTH) and latches mem_rdata as word0. T+3 is LD_CAPTURE, which latches word1.
  - Non-spanning load: T+2 is LD_CAPTURE.
  - Result = ({word1,word0} >> 8*addr[1:0]), low 8/16/32 bits, sign- or zero-extended per memop.
  - resp_valid: T+3 (single word) or T+4 (spanning).
- Stores:
  - Aligned store: one ST_WRITE cycle at T+1 with mem_addr=req_addr, native memop, we=1.
  - Misaligned store: one sb per byte i at addr+i (wrapping), byte i on mem_wdata[7:0], in ascending address order, consecutive cycles. 2 writes for sh, 4 for sw.
  - resp_valid the cycle after the last write: T+2, T+3 or T+5.
- Protocol rules:
  - resp_valid is exactly one cycle; RESP returns to IDLE.
  - A new request may be accepted in the cycle after resp_valid.
  - req_* are ignored while req_ready=0; the request is fully latched at accept.
- rst mid-operation: next cycle is IDLE with mem_we=0. In-flight access is abandoned, no resp_valid, partial stores are not rolled back.

Decomposition:
- Package lsu_pkg: MEMOP_LB/LH/LW/LBU/LHU constants, state enum, is_misaligned and is_spanning functions.
- One combinational sub-module, lsu_load_align: takes {word1,word0}, offset and memop; returns the extended 32-bit result.

Test Plan:
- Mem[0x100]=0x8899AABB; lb 0x103 -> T+3 resp_rdata=0xFFFFFF88; lbu 0x103 -> 0x00000088; one read each at mem_addr 0x100.
- Mem[0x100]=0x44332211, Mem[0x104]=0x88776655; lw 0x102 -> mem_addr 0x100 at T+1, 0x104 at T+2; resp_rdata=0x66554433 at T+4; lhu 0x103 -> 0x00005544.
- Mem[0x200]=0x11223344, Mem[0x204]=0x55667788; sw 0x201 data 0xDEADBEEF -> sb at 0x201..0x204 with bytes EF,BE,AD,DE; resp at T+5; then lw 0x200 -> 0xADBEEF44 and lw 0x204 -> 0x556677DE.
- ALLOW_MISALIGNED=0: lh 0x103 -> resp_valid=1, resp_err=1 at T+1, mem_we never high. memop 011 load -> same response.
- lw 0xFFFFFFFE -> mem_addr 0xFFFFFFFC then 0x00000000; result combines both words.
- rst asserted after second sb of a misaligned sw -> mem_we=0 the next cycle, no resp_valid; req_ready=1 after release; a following aligned sw completes at T+2.
